// File: rtl/axi_lite_arb_pkg.sv
// rtl/axi_lite_arb_pkg.sv - shared types and constants for the AXI-lite request arbiter
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Timer width that still holds the value TIMEOUT; never narrower than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/axi_lite_req_arbiter_rr_pick.sv
// rtl/axi_lite_req_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Scan from farthest to nearest offset so the requester closest to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - round-robin arbiter sharing one AXI-lite command stream
module axi_lite_req_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int ADDR_WD = 8,
    parameter int DATA_WD = 8,
    parameter int KEEP_WD = (ADDR_WD + DATA_WD) >> 3,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_wr,
    input  logic [NUM_REQ*ADDR_WD-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WD-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_WD-1:0]           rsp_rdata,
    output logic [1:0]                   rsp_resp,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         m_tvalid,
    output logic [ADDR_WD+DATA_WD-1:0]   m_tdata,
    output logic [KEEP_WD-1:0]           m_tkeep,
    input  logic                         m_tready,
    input  logic                         mon_bfire,
    input  logic [1:0]                   mon_bresp,
    input  logic                         mon_rfire,
    input  logic [DATA_WD-1:0]           mon_rdata,
    input  logic [1:0]                   mon_rresp
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = timer_width(TIMEOUT);

    arb_state_e          state, state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       g_idx;
    logic                cur_wr;
    logic [ADDR_WD-1:0]  cur_addr;
    logic [DATA_WD-1:0]  cur_data;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       timer_plus;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                accept;
    logic                done_evt;
    logic                timeout_evt;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept     = (state == ST_IDLE) && pick_any;
    assign timer_plus = (&timer) ? timer : timer + TW'(1);
    assign m_tdata    = {cur_addr, cur_data};
    assign m_tkeep    = {KEEP_WD{cur_wr}};

    // Next-state and handshake outputs; req_ready is held off while reset is asserted.
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        rsp_valid   = '0;
        m_tvalid    = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any && !rst) begin
                    req_ready = pick_grant;
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                m_tvalid = 1'b1;
                if (m_tready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                done_evt    = cur_wr ? mon_bfire : mon_rfire;
                timeout_evt = (TIMEOUT != 0) && (timer_plus == TW'(TIMEOUT));
                if (done_evt || timeout_evt) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[g_idx] = 1'b1;
                if (rsp_ready[g_idx]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, captured command, completion timer and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            g_idx     <= '0;
            cur_wr    <= 1'b0;
            cur_addr  <= '0;
            cur_data  <= '0;
            timer     <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (accept) begin
                g_idx    <= pick_idx;
                cur_wr   <= req_wr[pick_idx];
                cur_addr <= req_addr[pick_idx*ADDR_WD +: ADDR_WD];
                cur_data <= req_wr[pick_idx] ? req_wdata[pick_idx*DATA_WD +: DATA_WD] : '0;
            end
            if (state == ST_CMD && m_tready) timer <= '0;
            if (state == ST_WAIT) begin
                timer <= timer_plus;
                if (done_evt) begin
                    rsp_resp  <= cur_wr ? mon_bresp : mon_rresp;
                    rsp_rdata <= cur_wr ? '0 : mon_rdata;
                end else if (timeout_evt) begin
                    rsp_resp  <= RESP_SLVERR;
                    rsp_rdata <= '0;
                end
            end
            if (state == ST_RESP && rsp_ready[g_idx]) begin
                rr_ptr <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// tb/tb_axi_lite_req_arbiter.sv - directed self-checking bench for axi_lite_req_arbiter
module tb_axi_lite_req_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int KW = (AW + DW) >> 3;
    localparam int NR = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_wr, req_ready, rsp_valid, rsp_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, mon_rdata;
    logic [1:0]      rsp_resp, mon_bresp, mon_rresp;
    logic            m_tvalid, m_tready, mon_bfire, mon_rfire;
    logic [AW+DW-1:0] m_tdata;
    logic [KW-1:0]   m_tkeep;

    int checks   = 0;
    int failures = 0;

    axi_lite_req_arbiter #(
        .ADDR_WD(AW), .DATA_WD(DW), .KEEP_WD(KW), .NUM_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_ready(rsp_ready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tready(m_tready),
        .mon_bfire(mon_bfire), .mon_bresp(mon_bresp),
        .mon_rfire(mon_rfire), .mon_rdata(mon_rdata), .mon_rresp(mon_rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rq;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  mresp;
        logic [7:0]  mrdata;
        logic [15:0] exp_tdata;
        logic [1:0]  exp_tkeep;
        logic [7:0]  exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
        m_tready = 1'b0; mon_bfire = 1'b0; mon_bresp = 2'b00;
        mon_rfire = 1'b0; mon_rdata = '0; mon_rresp = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] oh;
        int fires;
        int early;

        vecs[0] = '{1, 1'b1, 8'h12, 8'h34, 2'b00, 8'h99, 16'h1234, 2'b11, 8'h00, 2'b00};
        vecs[1] = '{2, 1'b0, 8'h40, 8'hFF, 2'b00, 8'hA5, 16'h4000, 2'b00, 8'hA5, 2'b00};
        vecs[2] = '{0, 1'b1, 8'h7E, 8'h01, 2'b10, 8'h5A, 16'h7E01, 2'b11, 8'h00, 2'b10};
        vecs[3] = '{3, 1'b0, 8'hFF, 8'h77, 2'b01, 8'h3C, 16'hFF00, 2'b00, 8'h3C, 2'b01};

        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("reset_rsp_resp", 32'(rsp_resp), 32'h0);
        check("reset_m_tvalid", 32'(m_tvalid), 32'h0);
        check("reset_m_tdata", 32'(m_tdata), 32'h0);
        check("reset_m_tkeep", 32'(m_tkeep), 32'h0);
        rst = 1'b0;
        tick();

        // Table-driven single transactions; mon events of the right kind in the fire
        // cycle and of the wrong kind during WAIT must both be ignored.
        for (int v = 0; v < 4; v++) begin
            oh = NR'(1) << vecs[v].rq;
            req_valid = oh;
            req_wr[vecs[v].rq] = vecs[v].wr;
            req_addr[vecs[v].rq*AW +: AW] = vecs[v].addr;
            req_wdata[vecs[v].rq*DW +: DW] = vecs[v].wdata;
            #1;
            check("vec_req_ready", 32'(req_ready), 32'(oh));
            tick();
            idle_inputs();
            check("vec_m_tvalid", 32'(m_tvalid), 32'h1);
            check("vec_m_tdata", 32'(m_tdata), 32'(vecs[v].exp_tdata));
            check("vec_m_tkeep", 32'(m_tkeep), 32'(vecs[v].exp_tkeep));
            m_tready = 1'b1;
            mon_bfire = vecs[v].wr;
            mon_rfire = !vecs[v].wr;
            tick();
            idle_inputs();
            check("vec_m_tvalid_after_fire", 32'(m_tvalid), 32'h0);
            mon_bfire = !vecs[v].wr;
            mon_rfire = vecs[v].wr;
            tick();
            check("vec_wrong_event_ignored", 32'(rsp_valid), 32'h0);
            mon_bfire = vecs[v].wr;
            mon_rfire = !vecs[v].wr;
            mon_bresp = vecs[v].mresp;
            mon_rresp = vecs[v].mresp;
            mon_rdata = vecs[v].mrdata;
            tick();
            idle_inputs();
            check("vec_rsp_valid", 32'(rsp_valid), 32'(oh));
            check("vec_rsp_resp", 32'(rsp_resp), 32'(vecs[v].exp_resp));
            check("vec_rsp_rdata", 32'(rsp_rdata), 32'(vecs[v].exp_rdata));
            rsp_ready = oh;
            tick();
            rsp_ready = '0;
            check("vec_rsp_valid_done", 32'(rsp_valid), 32'h0);
        end

        // Round robin from reset with all four requesting continuously.
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            oh = NR'(1) << (i % NR);
            #1;
            check("rr_grant", 32'(req_ready), 32'(oh));
            tick();
            check("rr_ready_low_in_cmd", 32'(req_ready), 32'h0);
            m_tready = 1'b1; tick(); m_tready = 1'b0;
            mon_rfire = 1'b1; tick(); mon_rfire = 1'b0;
            check("rr_rsp_valid", 32'(rsp_valid), 32'(oh));
            rsp_ready = 4'hF; tick(); rsp_ready = '0;
        end
        idle_inputs();

        // Backpressure: payload held for 5 stalled cycles, exactly one fire.
        req_valid = 4'b0001; req_wr = 4'b0001; req_addr[7:0] = 8'h55; req_wdata[7:0] = 8'hAA;
        #1;
        check("bp_grant", 32'(req_ready), 32'h1);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            check("bp_tvalid_held", 32'(m_tvalid), 32'h1);
            check("bp_tdata_held", 32'(m_tdata), 32'h55AA);
            tick();
        end
        m_tready = 1'b1;
        fires = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_tvalid && m_tready) fires++;
            tick();
        end
        m_tready = 1'b0;
        check("bp_single_fire", 32'(fires), 32'h1);
        mon_bfire = 1'b1; tick(); mon_bfire = 1'b0;
        check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 4'b0001; tick(); rsp_ready = '0;

        // Timeout on a read while mon_bfire keeps pulsing.
        req_valid = 4'b0010; req_addr[15:8] = 8'h20;
        #1;
        check("to_grant", 32'(req_ready), 32'h2);
        tick();
        idle_inputs();
        m_tready = 1'b1; tick(); m_tready = 1'b0;
        early = 0;
        for (int i = 0; i < TO - 1; i++) begin
            mon_bfire = (i % 2 == 0);
            tick();
            if (rsp_valid != '0) early++;
        end
        mon_bfire = 1'b1;
        check("to_not_early", 32'(early), 32'h0);
        tick();
        mon_bfire = 1'b0;
        check("to_rsp_valid", 32'(rsp_valid), 32'h2);
        check("to_rsp_resp", 32'(rsp_resp), 32'h2);
        check("to_rsp_rdata", 32'(rsp_rdata), 32'h0);
        rsp_ready = 4'b0010; tick(); rsp_ready = '0;

        // Reset while waiting on a write completion.
        req_valid = 4'b0100; req_wr = 4'b0100; req_addr[23:16] = 8'hC3; req_wdata[23:16] = 8'h3C;
        #1;
        check("rst_grant", 32'(req_ready), 32'h4);
        tick();
        idle_inputs();
        m_tready = 1'b1; tick(); m_tready = 1'b0;
        tick();
        req_valid = 4'hF;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rsp_resp", 32'(rsp_resp), 32'h0);
        check("midrst_m_tvalid", 32'(m_tvalid), 32'h0);
        check("midrst_m_tdata", 32'(m_tdata), 32'h0);
        check("midrst_m_tkeep", 32'(m_tkeep), 32'h0);
        tick();
        mon_bfire = 1'b1;
        tick();
        mon_bfire = 1'b0;
        rst = 1'b0;
        #1;
        check("postrst_no_rsp", 32'(rsp_valid), 32'h0);
        check("postrst_grant0", 32'(req_ready), 32'h1);
        tick();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
